// File: rtl/monty_mul_iter.sv
// Iterative digit-serial LOGQ x LOGQ multiplier.
// B is consumed W bits per cycle (LSB digit first) against the full A; the
// 2*LOGQ-bit product feeds the word-level Montgomery reduction stage.
//
// state | meaning
// IDLE  | waiting for an operand pair
// BUSY  | accumulating one shifted partial product per cycle
// DONE  | product valid on C, waiting for downstream to take it
module monty_mul_iter #(
  parameter int LOGQ = 64,
  parameter int W    = 16,
  parameter int TAGW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LOGQ-1:0]   A,
  input  logic [LOGQ-1:0]   B,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*LOGQ-1:0] C,
  output logic [TAGW-1:0]   out_tag
);

  localparam int LAT  = LOGQ / W;
  localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int PW   = LOGQ + W;
  localparam int CW   = 2 * LOGQ;

  if (LOGQ % W != 0) begin : g_bad_digit_width
    $error("monty_mul_iter: LOGQ must be a multiple of W");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [LOGQ-1:0] a_q, a_d;
  logic [LOGQ-1:0] b_q, b_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   c_q, c_d;
  logic [TAGW-1:0] out_tag_q, out_tag_d;
  logic            out_valid_q, out_valid_d;

  logic [W-1:0]    digit;
  logic [PW-1:0]   pp;
  logic [CW-1:0]   acc_sum;
  logic            accept;

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    acc_d       = acc_q;
    c_d         = c_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;

    digit   = W'(b_q >> (32'(cnt_q) * W));
    pp      = PW'(a_q) * PW'(digit);
    acc_sum = acc_q + (CW'(pp) << (32'(cnt_q) * W));

    // Held low during reset so nothing is accepted while the block is cleared.
    in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    accept   = in_valid && in_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = A;
          b_d     = B;
          tag_d   = in_tag;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(LAT - 1)) begin
          c_d         = acc_sum;
          out_tag_d   = tag_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          // A new pair may be taken in the same cycle the result leaves.
          if (accept) begin
            a_d     = A;
            b_d     = B;
            tag_d   = in_tag;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      acc_q       <= '0;
      c_q         <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign C         = c_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_monty_mul_iter.sv
// Self-checking bench for monty_mul_iter: directed corner products,
// backpressure, back-to-back throughput, reset abort and random operands
// checked against a plain 128-bit multiply.
module tb_monty_mul_iter;

  localparam int LOGQ = 64;
  localparam int W    = 16;
  localparam int TAGW = 8;
  localparam int LAT  = LOGQ / W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [LOGQ-1:0]   A;
  logic [LOGQ-1:0]   B;
  logic [TAGW-1:0]   in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [2*LOGQ-1:0] C;
  logic [TAGW-1:0]   out_tag;

  int total = 0;
  int bad   = 0;

  monty_mul_iter #(.LOGQ(LOGQ), .W(W), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] wa, wb;
    wa = {64'd0, a};
    wb = {64'd0, b};
    return wa * wb;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, latency check, optional backpressure, handshake.
  task automatic do_txn(input logic [63:0] a, input logic [63:0] b,
                        input logic [7:0] tg, input int hold);
    logic [127:0] exp;
    logic [127:0] c_seen;
    int n;
    exp       = ref_mul(a, b);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    in_tag    = tg;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("in_ready_idle", {127'd0, in_ready}, 128'd1);
    step();
    in_valid = 1'b0;
    A        = 64'($urandom) << 32 | 64'($urandom);
    B        = 64'($urandom) << 32 | 64'($urandom);
    in_tag   = 8'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", 128'(n), 128'(LAT));
    chk("C", C, exp);
    chk("out_tag", {120'd0, out_tag}, {120'd0, tg});
    c_seen = C;
    for (int i = 0; i < hold; i++) begin
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      step();
      chk("bp_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_C", C, c_seen);
      chk("bp_tag", {120'd0, out_tag}, {120'd0, tg});
    end
    out_ready = 1'b1;
    #1;
    chk("done_in_ready", {127'd0, in_ready}, 128'd1);
    step();
    chk("valid_drop", {127'd0, out_valid}, 128'd0);
  endtask

  logic [63:0]  ops_a [3];
  logic [63:0]  ops_b [3];
  logic [127:0] expq [$];
  int           acc_t [3];
  int           idx;
  int           outs;
  logic         will_acc;
  logic         seen;
  logic [127:0] last_c;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; in_tag = '0;
    #2;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_C", C, 128'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

    do_txn(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 8'h5A, 0);
    chk("max_const", C, 128'hFFFFFFFFFFFFFFFE0000000000000001);
    do_txn(64'h800a000000000001, 64'd2, 8'h11, 0);
    chk("x2_const", C, 128'h00000000000000010014000000000002);
    do_txn(64'd0, 64'h123456789ABCDEF0, 8'h22, 0);
    chk("zero_const", C, 128'd0);
    do_txn(64'd1, 64'h8000000000000000, 8'h33, 0);
    chk("msb_const", C, 128'h00000000000000008000000000000000);
    last_c = C;

    // Idle with no input: C holds its last value.
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("idle_hold_C", C, last_c);
    chk("idle_valid", {127'd0, out_valid}, 128'd0);

    do_txn(64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 8'hA5, 5);

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      ops_a[i] = 64'($urandom) << 32 | 64'($urandom);
      ops_b[i] = 64'($urandom) << 32 | 64'($urandom);
    end
    idx = 0; outs = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A = ops_a[0]; B = ops_b[0]; in_tag = 8'd0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid && out_ready) begin
        if (expq.size() > 0) chk("b2b_C", C, expq.pop_front());
        else chk("b2b_extra_out", 128'd1, 128'd0);
        outs++;
      end
      will_acc = in_valid && in_ready;
      step();
      if (will_acc) begin
        expq.push_back(ref_mul(ops_a[idx], ops_b[idx]));
        acc_t[idx] = cyc;
        idx++;
        if (idx < 3) begin
          A = ops_a[idx]; B = ops_b[idx]; in_tag = 8'(idx);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_outs", 128'(outs), 128'd3);
    chk("b2b_accepts", 128'(idx), 128'd3);
    chk("b2b_gap1", 128'(acc_t[1] - acc_t[0]), 128'(LAT + 1));
    chk("b2b_gap2", 128'(acc_t[2] - acc_t[1]), 128'(LAT + 1));

    // Reset during the second BUSY cycle: transaction must vanish.
    in_valid = 1'b1;
    A = 64'h0F0F0F0F0F0F0F0F; B = 64'h1111111111111111; in_tag = 8'h77;
    step();              // accepted at this edge
    in_valid = 1'b0;
    step();              // first BUSY cycle done
    rst = 1'b1;
    #1;
    chk("abort_valid", {127'd0, out_valid}, 128'd0);
    chk("abort_C", C, 128'd0);
    chk("abort_in_ready", {127'd0, in_ready}, 128'd0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_late", {127'd0, seen}, 128'd0);

    // Random operands with random backpressure.
    for (int i = 0; i < 20; i++) begin
      do_txn(64'($urandom) << 32 | 64'($urandom),
             (i % 4 == 0) ? 64'($urandom) : (64'($urandom) << 32 | 64'($urandom)),
             8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/monty_mul_iter.md
Name: monty_mul_iter

Overview:
- Iterative digit-serial LOGQ x LOGQ integer multiplier.
- Produces the 2*LOGQ-bit product C consumed directly by the word-level Montgomery reduction stage (wlm / wlm_mixed), which sits immediately downstream.
- Operand B is processed W bits per cycle against the full A, trading throughput for DSP count.
- Valid/ready handshakes on both sides give the reduction pipeline a clean producer.

Parameters:
- LOGQ, 64, operand width in bits; the product is 2*LOGQ bits.
- W, 16, B digit width processed per cycle; LOGQ mod W must be 0, otherwise elaboration fails.
- TAGW, 8, width of a sideband tag carried unchanged from input to output.
- LAT (localparam), LOGQ/W, cycles from input acceptance to out_valid; exposed hierarchically for benches.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  A, B, in_tag valid.
- in_ready  out  1  block accepts an operand pair this cycle.
- A  in  LOGQ  multiplicand.
- B  in  LOGQ  multiplier, consumed LSB digit first.
- in_tag  in  TAGW  sideband tag.
- out_valid  out  1  C and out_tag valid.
- out_ready  in  1  downstream consumes C this cycle.
- C  out  2*LOGQ  product A*B; feeds the reduction stage C input.
- out_tag  out  TAGW  tag of the transaction on C.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; digit counter=0; accumulator, C and out_tag =0; out_valid=0.
  - in_ready=0 while rst is high.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept when in_valid & in_ready at a rising edge:
  - Latch A, B and in_tag; clear acc; cnt=0; go to BUSY.
- BUSY, each cycle:
  - acc <= acc + ((A * B[cnt*W +: W]) << (cnt*W)).
  - cnt increments.
  - On cnt==LAT-1, C <= final acc value, out_tag <= latched tag, out_valid <= 1, go to DONE.
- Latency: input accepted at edge E0 gives out_valid=1 after edge E0+LAT (LAT=4 at defaults).
- Arithmetic: acc is 2*LOGQ bits wide. No overflow is possible because A*B < 2^(2*LOGQ). Each partial product is LOGQ+W bits wide.
- DONE:
  - C, out_tag and out_valid are held stable until out_valid & out_ready.
  - On that handshake, out_valid drops on the next edge and the state goes to IDLE, unless a new input is accepted in the same cycle; then the state goes straight to BUSY.
  - Sustained throughput is one product per LAT+1 cycles.
- in_valid deasserted in IDLE: no state change; C holds its last value while out_valid=0.
- Inputs change while BUSY: ignored; only latched operands are used.
- Reset mid-operation (BUSY or DONE): transaction discarded; no out_valid is ever produced for it.
- out_ready is a don't-care while out_valid=0.

Test Plan:
- After reset, check in_ready=0 while rst=1, then 1; out_valid=0; C=0.
- A=B=0xFFFFFFFFFFFFFFFF, tag=0x5A, out_ready=1: expect C=0xFFFFFFFFFFFFFFFE0000000000000001 and out_tag=0x5A with out_valid high exactly LAT=4 cycles after acceptance.
- A=0x800a000000000001, B=2: expect C=0x00000000000000010014000000000002. Then feed this C to wlm_mixed to confirm the interface end to end.
- A=0, B=0x123456789ABCDEF0: expect C=0. A=1, B=0x8000000000000000: expect C=0x00000000000000008000000000000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Expect C and out_tag stable and in_ready=0 throughout, then one handshake and out_valid low the next cycle.
- Back-to-back and reset:
  - With in_valid and out_ready held high for 3 transactions, expect one new acceptance per 5 cycles and results in order.
  - Pulse rst during the 2nd BUSY cycle: expect out_valid=0, C=0, and no late output.
